// File: rtl/regfile_sb.sv
// regfile_sb: register file with a busy-bit scoreboard.
// Each entry has a data word and a busy bit. The issue side reserves an
// entry through alloc, and a later writeback stores the data and frees it.
// flush drops every reservation at once. busy_count is a registered
// popcount of the busy bits.
// Optional feature: define REGFILE_SB_BYPASS_EN so a same-cycle writeback
// is forwarded to the read ports. Without it, reads only show registered
// state.

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ready,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W:0]   busyCountNext;
    logic              wrAccept;
    logic              allocAccept;

    // With ZERO_REG set, entry 0 reads as zero and cannot be written or reserved.
    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Decide whether this cycle's writeback and alloc are accepted.
    // Address 0 always reports ready when hardwired, and reset forces ready high.
    always_comb begin
        wrAccept = wr_en && !reset && !isZeroAddr(wr_addr);
        if (reset) begin
            alloc_ready = 1'b1;
        end else if (isZeroAddr(alloc_addr)) begin
            alloc_ready = 1'b1;
        end else begin
            alloc_ready = !busy[alloc_addr] && !flush;
        end
        allocAccept = alloc_en && alloc_ready && !reset && !flush
                      && !isZeroAddr(alloc_addr);
    end

    // Next busy vector. An alloc is applied after the writeback clear, so a new
    // producer wins over a completing one. flush overrides both.
    always_comb begin
        busyNext = busy;
        if (wrAccept) begin
            busyNext[wr_addr] = 1'b0;
        end
        if (allocAccept) begin
            busyNext[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busyNext = '0;
        end
    end

    // Popcount of the next busy vector, so busy_count matches busy after every edge.
    always_comb begin
        busyCountNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busyCountNext = busyCountNext + {{ADDR_W{1'b0}}, busyNext[i]};
        end
    end

    // Data storage. Reset clears every entry; a writeback stores data even during flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrAccept) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Busy bits and their registered count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busyNext;
            busy_count <= busyCountNext;
        end
    end

    // Read port 1: registered state, plus optional forwarding of a same-cycle writeback.
    always_comb begin
        if (isZeroAddr(rd_addr1)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end else begin
            rd_data1 = regs[rd_addr1];
            rd_busy1 = busy[rd_addr1];
        end
`ifdef REGFILE_SB_BYPASS_EN
        if (wrAccept && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            if (!(allocAccept && (alloc_addr == rd_addr1))) begin
                rd_busy1 = 1'b0;
            end
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        if (isZeroAddr(rd_addr2)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end else begin
            rd_data2 = regs[rd_addr2];
            rd_busy2 = busy[rd_addr2];
        end
`ifdef REGFILE_SB_BYPASS_EN
        if (wrAccept && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            if (!(allocAccept && (alloc_addr == rd_addr2))) begin
                rd_busy2 = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with the default parameters.
// Stimulus pushes expected output values into a queue. A monitor on the
// falling clock edge pops them and compares each one against the DUT.

module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam int K_DATA1 = 0;
    localparam int K_DATA2 = 1;
    localparam int K_BUSY1 = 2;
    localparam int K_BUSY2 = 3;
    localparam int K_COUNT = 4;
    localparam int K_READY = 5;

    typedef struct {
        int          kind;
        logic [31:0] value;
        int          tag;
    } expItem_t;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rdAddr1, rdAddr2;
    logic [DATA_W-1:0] rdData1, rdData2;
    logic              rdBusy1, rdBusy2;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              allocEn;
    logic [ADDR_W-1:0] allocAddr;
    logic              allocReady;
    logic              flush;
    logic [ADDR_W:0]   busyCount;

    expItem_t sbQ[$];
    int checksTotal  = 0;
    int checksPassed = 0;
    int tagCounter   = 0;
    logic bypassOn;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr1    (rdAddr1),
        .rd_addr2    (rdAddr2),
        .rd_data1    (rdData1),
        .rd_data2    (rdData2),
        .rd_busy1    (rdBusy1),
        .rd_busy2    (rdBusy2),
        .wr_en       (wrEn),
        .wr_addr     (wrAddr),
        .wr_data     (wrData),
        .alloc_en    (allocEn),
        .alloc_addr  (allocAddr),
        .alloc_ready (allocReady),
        .flush       (flush),
        .busy_count  (busyCount)
    );

    // Free-running clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic string kindName(input int kind);
        case (kind)
            K_DATA1: return "rd_data1";
            K_DATA2: return "rd_data2";
            K_BUSY1: return "rd_busy1";
            K_BUSY2: return "rd_busy2";
            K_COUNT: return "busy_count";
            default: return "alloc_ready";
        endcase
    endfunction

    function automatic logic [31:0] dutValue(input int kind);
        case (kind)
            K_DATA1: return rdData1;
            K_DATA2: return rdData2;
            K_BUSY1: return {31'd0, rdBusy1};
            K_BUSY2: return {31'd0, rdBusy2};
            K_COUNT: return {27'd0, busyCount};
            default: return {31'd0, allocReady};
        endcase
    endfunction

    // Monitor: on each falling edge, compare every expectation queued this cycle.
    always @(negedge clk) begin
        while (sbQ.size() > 0) begin
            expItem_t item;
            logic [31:0] actual;
            item   = sbQ.pop_front();
            actual = dutValue(item.kind);
            checksTotal++;
            if (actual === item.value) begin
                checksPassed++;
            end else begin
                $display("[TB] FAIL %s#%0d actual=0x%08h required=0x%08h",
                         kindName(item.kind), item.tag, actual, item.value);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic ae,
                                 input logic [ADDR_W-1:0] aa, input logic fl,
                                 input logic [ADDR_W-1:0] ra1,
                                 input logic [ADDR_W-1:0] ra2);
        wrEn      = we;
        wrAddr    = wa;
        wrData    = wd;
        allocEn   = ae;
        allocAddr = aa;
        flush     = fl;
        rdAddr1   = ra1;
        rdAddr2   = ra2;
    endtask

    task automatic checkOutput(input int kind, input logic [31:0] value);
        expItem_t item;
        item.kind  = kind;
        item.value = value;
        item.tag   = tagCounter;
        tagCounter++;
        sbQ.push_back(item);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, ra1, ra2);
    endtask

    initial begin
`ifdef REGFILE_SB_BYPASS_EN
        bypassOn = 1'b1;
`else
        bypassOn = 1'b0;
`endif
        // While reset is high, try a write, alloc and flush to entry 4; all must be ignored.
        reset = 1'b1;
        applyStimulus(1'b1, 4'd4, 32'h11111111, 1'b1, 4'd4, 1'b1, 4'd4, 4'd4);
        checkOutput(K_READY, 32'd1);
        checkOutput(K_DATA1, 32'd0);
        checkOutput(K_BUSY1, 32'd0);
        checkOutput(K_COUNT, 32'd0);
        step();
        step();
        reset = 1'b0;

        // After reset every entry reads zero and nothing is busy.
        for (int a = 0; a < 16; a++) begin
            idle(4'(a), 4'(15 - a));
            checkOutput(K_DATA1, 32'd0);
            checkOutput(K_BUSY1, 32'd0);
            checkOutput(K_DATA2, 32'd0);
            checkOutput(K_BUSY2, 32'd0);
            checkOutput(K_COUNT, 32'd0);
            step();
        end

        // Reserve r5, then reserving it again must be refused.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, 4'd5, 4'd0);
        checkOutput(K_READY, 32'd1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, 4'd5, 4'd0);
        checkOutput(K_READY, 32'd0);
        checkOutput(K_COUNT, 32'd1);
        checkOutput(K_BUSY1, 32'd1);
        step();
        // Writeback to r5; the new value shows now only with forwarding.
        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, 4'd5, 4'd0);
        checkOutput(K_COUNT, 32'd1);
        checkOutput(K_DATA1, bypassOn ? 32'hDEADBEEF : 32'd0);
        checkOutput(K_BUSY1, bypassOn ? 32'd0 : 32'd1);
        step();
        idle(4'd5, 4'd0);
        checkOutput(K_DATA1, 32'hDEADBEEF);
        checkOutput(K_BUSY1, 32'd0);
        checkOutput(K_COUNT, 32'd0);
        step();

        // Same-cycle alloc and writeback on r3: data is written and busy stays set.
        applyStimulus(1'b1, 4'd3, 32'h12345678, 1'b1, 4'd3, 1'b0, 4'd3, 4'd0);
        checkOutput(K_READY, 32'd1);
        checkOutput(K_DATA1, bypassOn ? 32'h12345678 : 32'd0);
        step();
        idle(4'd3, 4'd0);
        checkOutput(K_BUSY1, 32'd1);
        checkOutput(K_DATA1, 32'h12345678);
        checkOutput(K_COUNT, 32'd1);
        step();

        // Reserve r1, r2 and r7, then flush with a writeback to r2 and an alloc to r8.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0);
        step();
        applyStimulus(1'b1, 4'd2, 32'hA5A5A5A5, 1'b1, 4'd8, 1'b1, 4'd7, 4'd2);
        checkOutput(K_COUNT, 32'd4);
        checkOutput(K_READY, 32'd0);
        checkOutput(K_BUSY1, 32'd1);
        checkOutput(K_DATA2, bypassOn ? 32'hA5A5A5A5 : 32'd0);
        checkOutput(K_BUSY2, bypassOn ? 32'd0 : 32'd1);
        step();
        idle(4'd8, 4'd2);
        checkOutput(K_COUNT, 32'd0);
        checkOutput(K_DATA2, 32'hA5A5A5A5);
        checkOutput(K_BUSY2, 32'd0);
        checkOutput(K_BUSY1, 32'd0);
        step();

        // Writes and allocs to r0 are ignored; r0 always reads zero and not busy.
        applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
        checkOutput(K_READY, 32'd1);
        checkOutput(K_DATA1, 32'd0);
        checkOutput(K_BUSY1, 32'd0);
        step();
        idle(4'd0, 4'd0);
        checkOutput(K_DATA1, 32'd0);
        checkOutput(K_BUSY2, 32'd0);
        checkOutput(K_COUNT, 32'd0);
        step();

        // A write to r9 is visible in the same cycle only when forwarding is enabled.
        applyStimulus(1'b1, 4'd9, 32'hCAFEF00D, 1'b0, '0, 1'b0, 4'd9, 4'd3);
        checkOutput(K_DATA1, bypassOn ? 32'hCAFEF00D : 32'd0);
        checkOutput(K_DATA2, 32'h12345678);
        step();
        idle(4'd9, 4'd0);
        checkOutput(K_DATA1, 32'hCAFEF00D);
        checkOutput(K_BUSY1, 32'd0);
        step();

        // Reserve every entry from 1 to 15, so busy_count reaches its maximum.
        for (int a = 1; a < 16; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 4'(a), 1'b0, 4'(a), 4'd0);
            checkOutput(K_READY, 32'd1);
            step();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd15, 1'b0, 4'd15, 4'd1);
        checkOutput(K_COUNT, 32'd15);
        checkOutput(K_READY, 32'd0);
        checkOutput(K_BUSY1, 32'd1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0);
        checkOutput(K_READY, 32'd1);
        step();
        idle(4'd15, 4'd0);
        checkOutput(K_COUNT, 32'd0);
        checkOutput(K_BUSY1, 32'd0);
        step();

        // Reserve r10 and r11, then assert reset in the middle of a writeback cycle.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd10, 1'b0, 4'd0, 4'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd0);
        step();
        idle(4'd10, 4'd11);
        checkOutput(K_COUNT, 32'd2);
        step();
        applyStimulus(1'b1, 4'd10, 32'h00000055, 1'b0, 4'd11, 1'b0, 4'd10, 4'd11);
        #1;
        reset = 1'b1;
        checkOutput(K_COUNT, 32'd0);
        checkOutput(K_BUSY1, 32'd0);
        checkOutput(K_BUSY2, 32'd0);
        checkOutput(K_DATA1, 32'd0);
        checkOutput(K_READY, 32'd1);
        step();
        reset = 1'b0;
        idle(4'd10, 4'd5);
        checkOutput(K_DATA1, 32'd0);
        checkOutput(K_DATA2, 32'd0);
        checkOutput(K_COUNT, 32'd0);
        step();

        // Let the monitor take the last expectations, then check that none are left.
        @(negedge clk);
        #1;
        if (sbQ.size() != 0) begin
            checksTotal++;
            $display("[TB] FAIL drain actual=%0d required=0", sbQ.size());
        end
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 rd_addr1, rd_addr2  input  ADDR_W each  read port addresses.
REQ-007 rd_data1, rd_data2  output  DATA_W each  read data.
REQ-008 rd_busy1, rd_busy2  output  1 each  entry at rd_addrN has a pending write.
REQ-009 wr_en  input  1  writeback strobe.
REQ-010 wr_addr  input  ADDR_W  writeback address.
REQ-011 wr_data  input  DATA_W  writeback data.
REQ-012 alloc_en  input  1  issue-side request to mark alloc_addr busy.
REQ-013 alloc_addr  input  ADDR_W  destination to reserve.
REQ-014 alloc_ready  output  1  alloc_addr may be reserved this cycle.
REQ-015 flush  input  1  clear all busy bits.
REQ-016 busy_count  output  ADDR_W+1  number of busy entries.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W plus one busy bit per entry.
REQ-018 Reads SHALL be combinational, zero latency, from registered state.
REQ-019 wr_en=1 SHALL write wr_data to wr_addr at the clock edge and clear its busy bit.
REQ-020 Writeback to a non-busy entry SHALL write data; busy stays 0.
REQ-021 alloc_ready SHALL be 1 when busy[alloc_addr]=0 and flush=0, else 0; combinational.
REQ-022 alloc_en=1 with alloc_ready=1 SHALL set busy[alloc_addr] at the edge; with alloc_ready=0 it SHALL be ignored.
REQ-023 Same-cycle accepted alloc and writeback to the same address SHALL leave busy set (new producer wins); data is still written.
REQ-024 flush=1 SHALL clear every busy bit at the edge; a same-cycle writeback still writes data; same-cycle alloc is ignored.
REQ-025 busy_count SHALL be registered, equal popcount of busy bits after each edge, range 0..DEPTH.
REQ-026 With ZERO_REG=1: reads of entry 0 return 0, rd_busy 0; writes and allocs to 0 ignored; alloc_ready=1 for address 0.
REQ-027 With ZERO_REG=0 entry 0 SHALL behave as any other entry.

Reset
REQ-028 reset=1 SHALL asynchronously clear all entries to 0, all busy bits to 0, busy_count to 0.
REQ-029 While reset=1, wr_en, alloc_en and flush SHALL have no effect; rd_data=0, rd_busy=0, alloc_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all pending reservations with no partial write.

Configuration
REQ-031 Macro REGFILE_SB_BYPASS_EN defined: when wr_en=1 and wr_addr==rd_addrN (excluding entry 0 if ZERO_REG=1), rd_dataN SHALL equal wr_data and rd_busyN SHALL equal 0 in the same cycle, unless that entry is concurrently alloc-accepted (rd_busyN stays 1 per REQ-023 result shown next cycle only).
REQ-032 Macro not defined: rd_dataN and rd_busyN SHALL reflect only registered state; written data visible the cycle after the write.

Verification
REQ-033 Reset, then read all 16 addresses -> rd_data=0x00000000, rd_busy=0, busy_count=0.
REQ-034 alloc r5; next cycle alloc r5 again -> alloc_ready=0, busy_count stays 1; wr r5=0xDEADBEEF -> busy clear, rd_data=0xDEADBEEF, busy_count=0.
REQ-035 Same cycle alloc r3 and wr r3=0x12345678 -> after edge rd_busy=1, rd_data=0x12345678.
REQ-036 alloc r1,r2,r7 then flush with wr r2=0xA5A5A5A5 -> busy_count=0, r2 reads 0xA5A5A5A5.
REQ-037 wr r0=0xFFFFFFFF, alloc r0 (ZERO_REG=1) -> rd_data 0, rd_busy 0, busy_count 0.
REQ-038 With REGFILE_SB_BYPASS_EN, wr r9=0xCAFEF00D, rd_addr1=9 same cycle -> rd_data1=0xCAFEF00D before edge; without macro -> old value until edge.
